// File: rtl/bsg_down_rx_buffer.sv
// Write side of the BSG downstream channel: registers the 8-bit link stream, packs byte pairs into a
// 16-bit entry buffer, commits the write pointer and returns credits. Optional: BSG_DOWN_RX_DROP_CNT_EN.
module bsg_down_rx_buffer #(
  parameter int ADDR_W      = 6,
  parameter int TOKEN_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_valid_in,
  input  logic [7:0]        io_data_in,
  input  logic [ADDR_W:0]   rptr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [15:0]       rd_data_o,
  output logic [ADDR_W:0]   wptr_t_o,
  output logic              full_o,
  output logic              io_token_out,
  output logic              overflow_o
`ifdef BSG_DOWN_RX_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt_o
`endif
);

  // Handshake: the link has no backpressure; a byte is taken on every cycle io_valid_in is high and
  // flow control is purely by io_token_out credits. Toward the reader, entries in [rptr_i, wptr_t_o)
  // are valid, and the reader frees one entry per cycle at most by advancing rptr_i.

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 2;

  localparam logic PHASE_LOW  = 1'b0;
  localparam logic PHASE_HIGH = 1'b1;

  logic              io_valid;
  logic [7:0]        io_data;
  logic              phase;
  logic [7:0]        low_byte;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr_seen;
  logic [CW-1:0]     credit_cnt;
  logic [15:0]       mem [DEPTH];

  logic              pair_done;
  logic              wr_en;
  logic              drop;
  logic [ADDR_W:0]   freed;
  logic [CW-1:0]     sum;

  assign full_o    = (wptr[ADDR_W] != rptr_i[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr_i[ADDR_W-1:0]);
  assign pair_done = io_valid && (phase == PHASE_HIGH);
  assign wr_en     = pair_done && !full_o;
  assign drop      = pair_done && full_o;
  assign rd_data_o = mem[rd_addr_i];
  assign freed     = rptr_i - rptr_seen;
  assign sum       = credit_cnt + CW'(freed);

  always_ff @(posedge clk) begin
    if (rst) begin
      io_valid <= 1'b0;
      io_data  <= 8'h00;
    end else begin
      io_valid <= io_valid_in;
      io_data  <= io_data_in;
    end
  end

  // Phase holds across idle gaps; a full buffer still completes the pair so the next byte is a low byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PHASE_LOW;
      low_byte   <= 8'h00;
      wptr       <= '0;
      overflow_o <= 1'b0;
    end else if (io_valid) begin
      if (phase == PHASE_LOW) begin
        low_byte <= io_data;
        phase    <= PHASE_HIGH;
      end else begin
        phase <= PHASE_LOW;
        if (full_o) overflow_o <= 1'b1;
        else        wptr       <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wptr[ADDR_W-1:0]] <= {io_data, low_byte};
  end

  // The extra commit register keeps a freshly written entry hidden until its data has settled.
  always_ff @(posedge clk) begin
    if (rst) wptr_t_o <= '0;
    else     wptr_t_o <= wptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_seen    <= '0;
      credit_cnt   <= '0;
      io_token_out <= 1'b0;
    end else begin
      rptr_seen <= rptr_i;
      if (sum >= CW'(TOKEN_WORDS)) begin
        io_token_out <= 1'b1;
        credit_cnt   <= sum - CW'(TOKEN_WORDS);
      end else begin
        io_token_out <= 1'b0;
        credit_cnt   <= sum;
      end
    end
  end

`ifdef BSG_DOWN_RX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                drop_cnt_o <= 16'h0000;
    else if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bsg_down_rx_buffer.sv
// Bench for bsg_down_rx_buffer: directed scenarios plus randomized traffic, a reader process that
// consumes entries and compares them against an expected-word queue, and credit counting.
module tb_bsg_down_rx_buffer;

  localparam int ADDR_W      = 6;
  localparam int TOKEN_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              io_valid_in;
  logic [7:0]        io_data_in;
  logic [ADDR_W:0]   rptr_i = '0;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [15:0]       rd_data_o;
  logic [ADDR_W:0]   wptr_t_o;
  logic              full_o;
  logic              io_token_out;
  logic              overflow_o;
`ifdef BSG_DOWN_RX_DROP_CNT_EN
  logic [15:0]       drop_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int mode = 0;  // 0 reader idle, 1 reader consumes, 2 reader steps for credit timing
  int consumed = 0;
  int tok_seen = 0;
  logic step_tgl = 1'b0;
  logic exp_tok = 1'b0;

  bsg_down_rx_buffer #(.ADDR_W(ADDR_W), .TOKEN_WORDS(TOKEN_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_valid_in  (io_valid_in),
    .io_data_in   (io_data_in),
    .rptr_i       (rptr_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .wptr_t_o     (wptr_t_o),
    .full_o       (full_o),
    .io_token_out (io_token_out),
    .overflow_o   (overflow_o)
`ifdef BSG_DOWN_RX_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  assign rd_addr_i = rptr_i[ADDR_W-1:0];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    io_valid_in = v;
    io_data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [15:0] w, input bit keep);
    drive(1'b1, w[7:0]);
    drive(1'b1, w[15:8]);
    if (keep) exp_q.push_back(w);
  endtask

  task automatic send_rand();
    logic [15:0] w;
    int n;
    w = 16'($urandom);
    n = 0;
    while (exp_q.size() >= 56 && n < 1000) begin
      idle(1);
      n++;
    end
    drive(1'b1, w[7:0]);
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    drive(1'b1, w[15:8]);
    exp_q.push_back(w);
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic do_reset();
    mode = 0;
    @(negedge clk);
    rst = 1'b1;
    io_valid_in = 1'b0;
    @(negedge clk);
    check("tok_in_rst", io_token_out, 1'b0);
    @(negedge clk);
    check("tok_in_rst", io_token_out, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wptr_t_o != rptr_i) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s: drain timeout got %0d words left expected 0", name, exp_q.size());
    end
  endtask

  // scoreboard / reader: consumes committed entries and checks them against the expected queue
  always @(negedge clk) begin
    if (rst) begin
      rptr_i   = '0;
      consumed = 0;
      tok_seen = 0;
      step_tgl = 1'b0;
      exp_tok  = 1'b0;
    end else begin
      if (io_token_out) tok_seen++;
      if (mode == 2) begin
        check("token_timing", io_token_out, exp_tok);
        exp_tok  = 1'b0;
        step_tgl = ~step_tgl;
        if (step_tgl && rptr_i < 8) begin
          rptr_i  = rptr_i + 1'b1;
          exp_tok = (rptr_i % TOKEN_WORDS == 0);
        end
      end else begin
        step_tgl = 1'b0;
        exp_tok  = 1'b0;
        if (mode == 1 && wptr_t_o != rptr_i && $urandom_range(0, 3) != 0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got entry %0h at rptr %0h expected none", rd_data_o, rptr_i);
          end else begin
            check("rd_data", rd_data_o, exp_q.pop_front());
          end
          rptr_i = rptr_i + 1'b1;
          consumed++;
        end
      end
    end
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1;
    io_valid_in = 1'b0;
    io_data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wptr", wptr_t_o, 0);
    check("rst_full", full_o, 0);
    check("rst_tok", io_token_out, 0);
    check("rst_ovf", overflow_o, 0);
`ifdef BSG_DOWN_RX_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt_o, 0);
`endif
    rst = 1'b0;

    // first pair and commit latency
    drive(1'b1, 8'h34);
    drive(1'b1, 8'h12);
    exp_q.push_back(16'h1234);
    drive(1'b0, 8'h00); check("lat_c1", wptr_t_o, 0);
    drive(1'b0, 8'h00); check("lat_c2", wptr_t_o, 0);
    drive(1'b0, 8'h00); check("lat_c3", wptr_t_o, 1);
    check("t1_full", full_o, 0);
    mode = 1;
    wait_drain("t1");

    // phase held across an idle gap
    do_reset();
    drive(1'b1, 8'hAA);
    idle(3);
    check("gap_no_write", wptr_t_o, 0);
    drive(1'b1, 8'hBB);
    exp_q.push_back(16'hBBAA);
    idle(3);
    check("gap_wptr", wptr_t_o, 1);
    mode = 1;
    wait_drain("gap");

    // fill to full, then one dropped word
    do_reset();
    for (int i = 0; i < 64; i++) send_word(16'($urandom), 1'b1);
    idle(3);
    check("fill_wptr", wptr_t_o, 7'h40);
    check("fill_full", full_o, 1);
    check("fill_ovf", overflow_o, 0);
    send_word(16'hDEAD, 1'b0);
    idle(3);
    check("drop_wptr", wptr_t_o, 7'h40);
    check("drop_ovf", overflow_o, 1);
`ifdef BSG_DOWN_RX_DROP_CNT_EN
    check("drop_cnt", drop_cnt_o, 1);
`endif
    mode = 1;
    wait_drain("fill");
    check("ovf_sticky", overflow_o, 1);
    check("drained_full", full_o, 0);

    // credit pulse timing with a reader stepping every other cycle
    do_reset();
    mode = 2;
    idle(22);
    mode = 0;
    idle(1);
    check("tok_pulses", tok_seen, 2);

    // reset in the middle of a pair discards the stale low byte
    do_reset();
    drive(1'b1, 8'h77);
    idle(1);
    do_reset();
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    exp_q.push_back(16'h2211);
    drive(1'b0, 8'h00);
    check("tok_after_rst", io_token_out, 0);
    idle(3);
    check("midrst_wptr", wptr_t_o, 1);
    mode = 1;
    wait_drain("midrst");

    // randomized traffic up to the pointer wrap point
    do_reset();
    mode = 1;
    for (int i = 0; i < 127; i++) send_rand();
    idle(1);
    wait_drain("rand_a");
    check("pre_wrap_wptr", wptr_t_o, 7'h7F);
    idle(3);
    check("rand_a_tokens", tok_seen, consumed / TOKEN_WORDS);
    mode = 0;
    w = 16'($urandom);
    send_word(w, 1'b1);
    idle(3);
    check("wrap_wptr", wptr_t_o, 7'h00);
    check("wrap_full", full_o, 0);
    mode = 1;
    wait_drain("wrap");

    for (int i = 0; i < 150; i++) send_rand();
    idle(1);
    wait_drain("rand_b");
    idle(3);
    check("rand_b_tokens", tok_seen, consumed / TOKEN_WORDS);
    check("rand_b_ovf", overflow_o, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
